// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: DIV_WIDTH operand width, state_t FSM encoding, cond_neg helper
// that yields the two's-complement negation of a value when neg is set.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Magnitude / sign application helper: -v when neg, else v.
  function automatic logic [DIV_WIDTH-1:0] cond_neg(input logic [DIV_WIDTH-1:0] v,
                                                    input logic                 neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/subtractor33.sv
// 33-bit trial subtractor: diff = a - b computed as a + ~b + 1 on a ripple-carry chain.
// Latency: combinational.
// Backpressure: none (pure datapath).
//
// Ports: a_i/b_i 33-bit operands; diff_o 33-bit difference; borrow_o = ~carry_out
// (1 when a_i < b_i as unsigned).
module subtractor33 (
  input  logic [32:0] a_i,
  input  logic [32:0] b_i,
  output logic [32:0] diff_o,
  output logic        borrow_o
);

  logic [32:0] nb;
  assign nb = ~b_i;

  always_comb begin
    logic carry;
    carry  = 1'b1;  // the +1 of the two's-complement subtraction
    diff_o = '0;
    for (int i = 0; i < 33; i++) begin
      diff_o[i] = a_i[i] ^ nb[i] ^ carry;
      carry     = (a_i[i] & nb[i]) | (carry & (a_i[i] ^ nb[i]));
    end
    borrow_o = ~carry;
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, signed/unsigned, one quotient bit per cycle.
// Latency: valid_o 33 edges after the accepting edge (1 edge for divide-by-zero).
// Backpressure: start_i is ignored while busy_o=1; no queueing.
//
// Ports: clk_i, rst_i (sync, active-high); start_i/signed_i/dividend_i/divisor_i
// request; busy_o, valid_o (1-cycle pulse), quotient_o, remainder_o, div_by_zero_o.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH  // datapath is built around 33-bit trial subtraction
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  state_t           state_q;
  logic [5:0]       cnt_q;
  logic [WIDTH-1:0] dvd_q;      // dividend magnitude, shifted out MSB first
  logic [WIDTH-1:0] dvs_q;      // divisor magnitude
  logic [WIDTH-1:0] quot_q;     // working quotient
  logic [WIDTH:0]   rem_q;      // partial remainder (one guard bit)
  logic             q_neg_q;
  logic             r_neg_q;
  logic             dbz_pend_q;

  logic             busy_q;
  logic             valid_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             div_by_zero_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH:0]   shift_rem;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] quot_d;

  assign a_neg = signed_i & dividend_i[WIDTH-1];
  assign b_neg = signed_i & divisor_i[WIDTH-1];

  // Bring down the next dividend bit into the partial remainder.
  assign shift_rem = (rem_q << 1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};

  subtractor33 u_sub (
    .a_i      (shift_rem),
    .b_i      ({1'b0, dvs_q}),
    .diff_o   (diff),
    .borrow_o (borrow)
  );

  // Restore on borrow, otherwise keep the difference and emit a 1.
  assign rem_d  = borrow ? shift_rem : diff;
  assign quot_d = {quot_q[WIDTH-2:0], ~borrow};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      dvd_q         <= '0;
      dvs_q         <= '0;
      quot_q        <= '0;
      rem_q         <= '0;
      q_neg_q       <= 1'b0;
      r_neg_q       <= 1'b0;
      dbz_pend_q    <= 1'b0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            busy_q        <= 1'b1;
            div_by_zero_q <= 1'b0;
            q_neg_q       <= a_neg ^ b_neg;
            r_neg_q       <= a_neg;
            dvd_q         <= cond_neg(dividend_i, a_neg);
            dvs_q         <= cond_neg(divisor_i, b_neg);
            cnt_q         <= '0;
            if (divisor_i == '0) begin
              // Result is fixed: all-ones quotient, raw dividend as remainder.
              dbz_pend_q <= 1'b1;
              quot_q     <= '1;
              rem_q      <= {1'b0, dividend_i};
              state_q    <= DONE;
            end else begin
              dbz_pend_q <= 1'b0;
              quot_q     <= '0;
              rem_q      <= '0;
              state_q    <= CALC;
            end
          end
        end
        CALC: begin
          dvd_q <= dvd_q << 1;
          if (cnt_q == 6'(WIDTH - 1)) begin
            // Last bit: fold in sign correction so DONE only copies out.
            quot_q  <= q_neg_q ? (~quot_d + 1'b1) : quot_d;
            rem_q   <= r_neg_q ? (~rem_d + 1'b1) : rem_d;
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_q + 6'd1;
          end
        end
        DONE: begin
          state_q       <= IDLE;
          busy_q        <= 1'b0;
          valid_q       <= 1'b1;
          quotient_q    <= quot_q;
          remainder_q   <= rem_q[WIDTH-1:0];
          div_by_zero_q <= dbz_pend_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign valid_o       = valid_q;
  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = div_by_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider with a result scoreboard.
// Latency: expects valid_o 33 edges after acceptance, 1 edge for divide-by-zero.
// Backpressure: exercises starts issued while busy (ignored) and back-to-back starts.
module tb_seq_divider;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;
  logic        div_by_zero_o;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .signed_i      (signed_i),
    .dividend_i    (dividend_i),
    .divisor_i     (divisor_i),
    .busy_o        (busy_o),
    .valid_o       (valid_o),
    .quotient_o    (quotient_o),
    .remainder_o   (remainder_o),
    .div_by_zero_o (div_by_zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from the language's own division operators.
  function automatic exp_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.z = 1'b0;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
      e.z = 1'b1;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = 32'h8000_0000;
        e.r = 32'd0;
      end else begin
        e.q = $signed(a) / $signed(b);
        e.r = $signed(a) % $signed(b);
      end
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Drives one accepting edge; optionally records the expected result.
  task automatic do_start(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input bit push);
    start_i    = 1'b1;
    signed_i   = sgn;
    dividend_i = a;
    divisor_i  = b;
    step();
    start_i = 1'b0;
    if (push) sb.push_back(model(sgn, a, b));
  endtask

  // Steps from edge n0 until valid_o; checks latency, busy, held outputs and the result.
  task automatic wait_result(input string tag, input int n0, input int exp_lat);
    int          n;
    bit          seen;
    bit          held_ok;
    bit          busy_ok;
    logic [31:0] q0;
    logic [31:0] r0;
    exp_t        e;
    n       = n0;
    seen    = 1'b0;
    held_ok = 1'b1;
    busy_ok = 1'b1;
    q0      = quotient_o;
    r0      = remainder_o;
    while (!seen && n < 200) begin
      step();
      n++;
      if (valid_o) seen = 1'b1;
      else begin
        if (quotient_o !== q0 || remainder_o !== r0) held_ok = 1'b0;
        if (busy_o !== 1'b1) busy_ok = 1'b0;
      end
    end
    chk({tag, "_valid_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_outputs_held"}, 32'(held_ok), 32'd1);
    chk({tag, "_busy_while_running"}, 32'(busy_ok), 32'd1);
    if (seen) begin
      chk({tag, "_busy_low_at_valid"}, 32'(busy_o), 32'd0);
      chk({tag, "_result_expected"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({tag, "_quotient"}, quotient_o, e.q);
        chk({tag, "_remainder"}, remainder_o, e.r);
        chk({tag, "_div_by_zero"}, 32'(div_by_zero_o), 32'(e.z));
      end
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    bit          stray;

    // Reset state
    step();
    step();
    rst_i = 1'b0;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_quotient", quotient_o, 32'd0);
    chk("rst_remainder", remainder_o, 32'd0);
    chk("rst_dbz", 32'(div_by_zero_o), 32'd0);

    // Unsigned 100 / 7, then the pulse must drop after one cycle
    do_start(1'b0, 32'd100, 32'd7, 1'b1);
    chk("u100_7_busy_after_accept", 32'(busy_o), 32'd1);
    wait_result("u100_7", 0, 33);
    step();
    chk("u100_7_pulse_width", 32'(valid_o), 32'd0);
    chk("u100_7_results_held", quotient_o, 32'd14);

    // Signed -7 / 2
    do_start(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_result("s_m7_2", 0, 33);

    // Divide by zero
    do_start(1'b0, 32'd5, 32'd0, 1'b1);
    wait_result("dbz_5_0", 0, 1);
    step();
    chk("dbz_pulse_width", 32'(valid_o), 32'd0);
    chk("dbz_flag_held", 32'(div_by_zero_o), 32'd1);

    // Signed overflow and unsigned all-ones / 1
    do_start(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_result("s_overflow", 0, 33);
    do_start(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1);
    wait_result("u_max_1", 0, 33);

    // Mixed signs and a large unsigned divisor
    do_start(1'b1, 32'd100, 32'hFFFF_FFF9, 1'b1);
    wait_result("s_100_m7", 0, 33);
    do_start(1'b0, 32'hF000_0001, 32'h8000_0000, 1'b1);
    wait_result("u_big_div", 0, 33);

    // Random operands, both modes
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      rs = 1'($urandom_range(0, 1));
      if (rb == 32'd0) rb = 32'd3;
      do_start(rs, ra, rb, 1'b1);
      wait_result("random", 0, 33);
    end

    // Start pulsed mid-operation must be ignored
    do_start(1'b0, 32'd100, 32'd7, 1'b1);
    for (int i = 1; i < 10; i++) step();
    start_i    = 1'b1;
    dividend_i = 32'd9;
    divisor_i  = 32'd3;
    step();
    start_i = 1'b0;
    wait_result("ignored_start", 10, 33);

    // Reset during CALC aborts with no later pulse
    do_start(1'b0, 32'd100, 32'd7, 1'b0);
    for (int i = 1; i < 20; i++) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_valid", 32'(valid_o), 32'd0);
    chk("abort_quotient", quotient_o, 32'd0);
    chk("abort_remainder", remainder_o, 32'd0);
    chk("abort_dbz", 32'(div_by_zero_o), 32'd0);
    stray = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (valid_o || busy_o) stray = 1'b1;
    end
    chk("abort_no_later_activity", 32'(stray), 32'd0);

    // Back-to-back: start held through DONE (ignored) and the following IDLE edge (accepted)
    do_start(1'b0, 32'd1000, 32'd33, 1'b1);
    for (int i = 1; i < 33; i++) step();
    start_i    = 1'b1;
    signed_i   = 1'b1;
    dividend_i = 32'hFFFF_FC18;  // -1000
    divisor_i  = 32'd7;
    wait_result("b2b_first", 32, 33);
    step();
    start_i = 1'b0;
    sb.push_back(model(1'b1, 32'hFFFF_FC18, 32'd7));
    chk("b2b_second_accepted", 32'(busy_o), 32'd1);
    wait_result("b2b_second", 0, 33);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
